// File: rtl/skew_feeder.sv
// Tile loader for the systolic-array shift-register bank: accepts BUFFER_SIZE row vectors,
// feeds them into the lanes with a diagonal skew, then pulses the bank read enable.
module skew_feeder #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned BUFFER_SIZE  = 9,
    parameter int unsigned BUFFER_COUNT = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic [BUFFER_COUNT*DATA_WIDTH-1:0] s_data,
    output logic [BUFFER_COUNT-1:0]            in_valid,
    output logic [BUFFER_COUNT*DATA_WIDTH-1:0] data_out,
    output logic                               read_en,
    output logic                               busy,
    output logic                               done
);

    localparam int unsigned MaxLen = (BUFFER_SIZE > BUFFER_COUNT) ? BUFFER_SIZE : BUFFER_COUNT;
    localparam int unsigned CntW   = $clog2(MaxLen) + 1;

    localparam logic [CntW-1:0] LastBeat  = CntW'(BUFFER_SIZE - 1);
    localparam logic [CntW-1:0] LastFlush = CntW'(BUFFER_COUNT - 1);
    localparam logic [CntW-1:0] LastRead  = CntW'(BUFFER_SIZE - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StFlush, StRead} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            s_ready_q;
    logic            busy_q;
    logic            read_en_q;
    logic            done_q;
    logic            accept;

    assign accept = s_valid && s_ready_q;

    // One counter is shared by LOAD (beats), FLUSH (skew drain) and READ (read_en length).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            read_en_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q   <= StLoad;
                        cnt_q     <= '0;
                        s_ready_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                StLoad: begin
                    if (accept) begin
                        if (cnt_q == LastBeat) begin
                            state_q   <= StFlush;
                            cnt_q     <= '0;
                            s_ready_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                end
                StFlush: begin
                    if (cnt_q == LastFlush) begin
                        state_q   <= StRead;
                        cnt_q     <= '0;
                        read_en_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StRead: begin
                    if (cnt_q == LastRead) begin
                        state_q   <= StIdle;
                        cnt_q     <= '0;
                        read_en_q <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign s_ready = s_ready_q;
    assign busy    = busy_q;
    assign read_en = read_en_q;
    assign done    = done_q;

    // Lane i is a free-running delay line of i+1 stages; stage 0 keeps its old data on bubbles.
    for (genvar i = 0; i < BUFFER_COUNT; i++) begin : g_lane
        logic [i:0][DATA_WIDTH-1:0] dat_q;
        logic [i:0]                 vld_q;
        logic [DATA_WIDTH-1:0]      head_d;

        assign head_d = accept ? s_data[i*DATA_WIDTH +: DATA_WIDTH] : dat_q[0];

        if (i == 0) begin : g_tap
            always_ff @(posedge clk) begin
                if (rst) begin
                    dat_q <= '0;
                    vld_q <= '0;
                end else begin
                    dat_q <= head_d;
                    vld_q <= accept;
                end
            end
        end else begin : g_line
            always_ff @(posedge clk) begin
                if (rst) begin
                    dat_q <= '0;
                    vld_q <= '0;
                end else begin
                    dat_q <= {dat_q[i-1:0], head_d};
                    vld_q <= {vld_q[i-1:0], accept};
                end
            end
        end

        assign in_valid[i]                          = vld_q[i];
        assign data_out[i*DATA_WIDTH +: DATA_WIDTH] = dat_q[i];
    end

endmodule

// File: tb/tb_skew_feeder.sv
// Bench for skew_feeder: directed vector table, corner-case sequences and a random run
// checked every cycle against a timeline model of the tile protocol.
module tb_skew_feeder;

    localparam int DW   = 8;
    localparam int BS   = 9;
    localparam int BC   = 16;
    localparam int MAXP = 4096;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              s_valid;
    logic              s_ready;
    logic [BC*DW-1:0]  s_data;
    logic [BC-1:0]     in_valid;
    logic [BC*DW-1:0]  data_out;
    logic              read_en;
    logic              busy;
    logic              done;

    skew_feeder #(
        .DATA_WIDTH  (DW),
        .BUFFER_SIZE (BS),
        .BUFFER_COUNT(BC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .in_valid(in_valid),
        .data_out(data_out),
        .read_en (read_en),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [BC*DW-1:0] beat_data(input int k);
        logic [BC*DW-1:0] d;
        for (int i = 0; i < BC; i++) begin
            d[i*DW +: DW] = (k < 0) ? 8'hEE : 8'(16 * k + i);
        end
        return d;
    endfunction

    // Timeline model: p = number of clock edges seen; period p is the time after edge p.
    // A beat accepted at edge e is seen on lane i in period e+i; once the last beat lands at
    // edge tL, the bank is busy through tL+BC+BS-1, read_en covers the last BS of those
    // periods and done follows.
    int               p = 0;
    int               reset_edge = 0;
    int               m_tl = -1000;
    int               m_beats = 0;
    bit               m_loading = 0;
    bit               model_ok = 0;
    bit               acc [MAXP];
    logic [BC*DW-1:0] held [MAXP];

    function automatic bit model_busy(input int q);
        return m_loading || (q >= m_tl && q <= m_tl + BC + BS - 1);
    endfunction

    always @(posedge clk) begin
        int e;
        bit busy_now;
        bit acc_now;
        e        = p + 1;
        busy_now = model_busy(p);
        if (rst) begin
            reset_edge = e;
            model_ok   = 1;
            m_loading  = 0;
            m_tl       = -1000;
            acc[e]     = 0;
            held[e]    = '0;
        end else if (model_ok) begin
            acc_now = m_loading && s_valid;
            acc[e]  = acc_now;
            held[e] = acc_now ? s_data : held[e-1];
            if (!busy_now && start) begin
                m_loading = 1;
                m_beats   = 0;
            end else if (acc_now) begin
                m_beats++;
                if (m_beats == BS) begin
                    m_loading = 0;
                    m_tl      = e;
                end
            end
        end
        p = e;
    end

    always @(negedge clk) begin
        logic [BC-1:0]    e_iv;
        logic [BC*DW-1:0] e_do;
        int               e;
        if (model_ok) begin
            for (int i = 0; i < BC; i++) begin
                e = p - i;
                if (e <= reset_edge) begin
                    e_iv[i]         = 1'b0;
                    e_do[i*DW +: DW] = '0;
                end else begin
                    e_iv[i]         = acc[e];
                    e_do[i*DW +: DW] = held[e][i*DW +: DW];
                end
            end
            chk("mon_s_ready", 128'(s_ready), 128'(m_loading));
            chk("mon_busy", 128'(busy), 128'(model_busy(p)));
            chk("mon_read_en", 128'(read_en), 128'(p >= m_tl + BC && p <= m_tl + BC + BS - 1));
            chk("mon_done", 128'(done), 128'(p == m_tl + BC + BS));
            chk("mon_in_valid", 128'(in_valid), 128'(e_iv));
            chk("mon_data_out", 128'(data_out), 128'(e_do));
        end
    end

    task automatic drive(input bit r, input bit s, input bit v, input int k);
        rst     = r;
        start   = s;
        s_valid = v;
        s_data  = beat_data(k);
    endtask

    typedef struct {
        bit          rst;
        bit          start;
        bit          vld;
        int          beat;
        bit          e_rdy;
        bit          e_busy;
        bit          e_rd;
        bit          e_done;
        logic [15:0] e_iv;
        logic [7:0]  e_d0;
    } vec_t;

    vec_t tbl [7];

    int first_rd, n_rd, done_off, n_done, n_rdy, n_l15, busy_at_done, rd_after_rst;
    int done1, done2, rdy_after, overlap;

    initial begin
        drive(1, 0, 0, 0);
        repeat (2) @(posedge clk);

        // Expectations are for the period after the row's inputs are sampled.
        tbl[0] = '{1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00};
        tbl[1] = '{1'b0, 1'b0, 1'b1, -1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00};
        tbl[2] = '{1'b0, 1'b1, 1'b0, -1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00};
        tbl[3] = '{1'b0, 1'b1, 1'b1,  0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0001, 8'h00};
        tbl[4] = '{1'b0, 1'b0, 1'b1,  1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0003, 8'h10};
        tbl[5] = '{1'b0, 1'b0, 1'b0, -1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0006, 8'h10};
        tbl[6] = '{1'b0, 1'b0, 1'b1,  2, 1'b1, 1'b1, 1'b0, 1'b0, 16'h000D, 8'h20};

        for (int r = 0; r < 7; r++) begin
            @(negedge clk);
            drive(tbl[r].rst, tbl[r].start, tbl[r].vld, tbl[r].beat);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_s_ready", r), 128'(s_ready), 128'(tbl[r].e_rdy));
            chk($sformatf("tbl%0d_busy", r), 128'(busy), 128'(tbl[r].e_busy));
            chk($sformatf("tbl%0d_read_en", r), 128'(read_en), 128'(tbl[r].e_rd));
            chk($sformatf("tbl%0d_done", r), 128'(done), 128'(tbl[r].e_done));
            chk($sformatf("tbl%0d_in_valid", r), 128'(in_valid), 128'(tbl[r].e_iv));
            chk($sformatf("tbl%0d_lane0", r), 128'(data_out[7:0]), 128'(tbl[r].e_d0));
        end

        // Finish the bubbled tile, then poke start/s_valid through FLUSH and READ.
        for (int k = 3; k < BS; k++) begin
            @(negedge clk);
            drive(0, 0, 1, k);
        end
        @(posedge clk);
        #1;
        first_rd = -1; n_rd = 0; done_off = -1; n_done = 0; n_rdy = 0; n_l15 = 0;
        busy_at_done = -1;
        for (int off = 0; off < 40; off++) begin
            if (read_en) begin
                if (first_rd < 0) first_rd = off;
                n_rd++;
            end
            if (done) begin
                n_done++;
                done_off     = off;
                busy_at_done = int'(busy);
            end
            if (s_ready) n_rdy++;
            if (in_valid[BC-1]) n_l15++;
            @(negedge clk);
            drive(0, off < 20, off < 20, -1);
            @(posedge clk);
            #1;
        end
        chk("bub_first_read", 128'(first_rd), 128'(BC));
        chk("bub_read_len", 128'(n_rd), 128'(BS));
        chk("bub_done_off", 128'(done_off), 128'(BC + BS));
        chk("bub_done_count", 128'(n_done), 128'(1));
        chk("bub_busy_at_done", 128'(busy_at_done), 128'(0));
        chk("bub_no_ready", 128'(n_rdy), 128'(0));
        chk("bub_lane15_beats", 128'(n_l15), 128'(BS));

        // Reset sampled at edge tL+5, in the middle of FLUSH.
        @(negedge clk);
        drive(0, 1, 0, -1);
        for (int k = 0; k < BS; k++) begin
            @(negedge clk);
            drive(0, 0, 1, k);
        end
        @(posedge clk);
        #1;
        rd_after_rst = 0;
        for (int off = 0; off < 40; off++) begin
            if (read_en) rd_after_rst++;
            if (off == 5) begin
                chk("rst_in_valid", 128'(in_valid), 128'(0));
                chk("rst_data_out", 128'(data_out), 128'(0));
                chk("rst_busy", 128'(busy), 128'(0));
                chk("rst_s_ready", 128'(s_ready), 128'(0));
            end
            @(negedge clk);
            drive(off == 4, 0, 0, -1);
            @(posedge clk);
            #1;
        end
        chk("rst_no_read", 128'(rd_after_rst), 128'(0));

        // Back-to-back tiles with start and s_valid held high.
        @(negedge clk);
        drive(0, 1, 1, 0);
        @(posedge clk);
        #1;
        done1 = -1; done2 = -1; rdy_after = -1; overlap = 0;
        for (int off = 0; off < 80; off++) begin
            if (done) begin
                if (done1 < 0) done1 = off;
                else if (done2 < 0) done2 = off;
            end
            if (done1 >= 0 && off == done1 + 1) rdy_after = int'(s_ready);
            if (read_en && s_ready) overlap++;
            @(negedge clk);
            drive(0, 1, 1, off + 1);
            @(posedge clk);
            #1;
        end
        chk("b2b_done1", 128'(done1), 128'(BS + BC + BS));
        chk("b2b_done2", 128'(done2), 128'(2 * (BS + BC + BS) + 1));
        chk("b2b_reload", 128'(rdy_after), 128'(1));
        chk("b2b_overlap", 128'(overlap), 128'(0));

        // Random traffic, checked by the per-cycle monitor.
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            rst     = ($urandom_range(0, 299) == 0);
            start   = ($urandom_range(0, 3) == 0);
            s_valid = ($urandom_range(0, 9) < 7);
            s_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        @(negedge clk);
        drive(0, 0, 0, -1);
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
